// File: rtl/muldiv_wb_unit.sv
// Iterative unsigned multiply/divide unit: 32 shift-add or restoring-divide
// steps, then holds the result on the shared regfile write port until granted.
module muldiv_wb_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       dst,
   input  logic             flush,
   output logic             busy,
   output logic             wb_we,
   output logic [4:0]       wb_wn,
   output logic [WIDTH-1:0] wb_d,
   input  logic             wb_gnt
);

   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         op_q;
   logic [4:0]         dst_q;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH:0]     mul_sum, div_top, div_diff;
   logic               accept, last;

   assign accept = (state == IDLE) && start && !flush;
   assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

   // acc is the product register for MUL/MULHU and {remainder, quotient} for DIVU/REMU
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_top  = acc[2*WIDTH-1:WIDTH-1];
      div_diff = div_top - {1'b0, opnd};
      if (!op_q[1])
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
         acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_step = {div_top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = RUN;
         RUN: begin
            if (flush)
               state_next = IDLE;
            else if (last)
               state_next = (dst_q != 5'd0) ? WB : IDLE;  // r0 writes are dropped
         end
         WB: if (flush || wb_gnt) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt   <= '0;
         op_q  <= '0;
         dst_q <= '0;
         opnd  <= '0;
         acc   <= '0;
      end else if (accept) begin
         cnt   <= '0;
         op_q  <= op;
         dst_q <= dst;
         opnd  <= op[1] ? b : a;
         acc   <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
      end else if (state == RUN && !flush) begin
         cnt   <= cnt + CNT_W'(1);
         acc   <= acc_step;
      end
   end

   assign busy  = (state != IDLE);
   assign wb_we = (state == WB);
   assign wb_wn = dst_q;
   assign wb_d  = op_q[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Directed bench for muldiv_wb_unit: arithmetic, latency, stall, flush, r0 and reset.
module tb_muldiv_wb_unit;

   logic        clk = 1'b0;
   logic        clrn, start, flush, wb_gnt;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [4:0]  dst;
   logic        busy, wb_we;
   logic [4:0]  wb_wn;
   logic [31:0] wb_d;

   int total = 0;
   int bad   = 0;

   muldiv_wb_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b), .dst(dst),
      .flush(flush), .busy(busy), .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
      .wb_gnt(wb_gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with wb_gnt=1 and check the full 33-cycle timeline.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] d, input logic [31:0] exp);
      logic early;
      op = o; a = x; b = y; dst = d; start = 1'b1;
      step();
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      early = 1'b0;
      repeat (31) begin
         step();
         if (wb_we) early = 1'b1;
      end
      chk({tag, "_early_we"}, {31'd0, early}, 32'd0);
      step();
      chk({tag, "_we"}, {31'd0, wb_we}, 32'd1);
      chk({tag, "_wn"}, {27'd0, wb_wn}, {27'd0, d});
      chk({tag, "_d"}, wb_d, exp);
      step();
      chk({tag, "_we_off"}, {31'd0, wb_we}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic seen;
      clrn = 1'b0; start = 1'b0; flush = 1'b0; wb_gnt = 1'b1;
      op = 2'd0; a = '0; b = '0; dst = '0;
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_we", {31'd0, wb_we}, 32'd0);
      chk("rst_wn", {27'd0, wb_wn}, 32'd0);
      chk("rst_d", wb_d, 32'd0);
      step();
      clrn = 1'b1;
      step();

      run_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42);
      run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
      run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001);
      run_op("divu", 2'b10, 32'd100, 32'd7, 5'd8, 32'd14);
      run_op("remu", 2'b11, 32'd100, 32'd7, 5'd8, 32'd2);
      run_op("divu_z", 2'b10, 32'h1234, 32'd0, 5'd8, 32'hFFFF_FFFF);
      run_op("remu_z", 2'b11, 32'h1234, 32'd0, 5'd8, 32'h0000_1234);

      // Writeback stall with noisy start/operands; completion start is ignored.
      wb_gnt = 1'b0;
      op = 2'b00; a = 32'd1000; b = 32'd3; dst = 5'd9; start = 1'b1;
      step();
      start = 1'b0;
      repeat (32) step();
      chk("stall_we0", {31'd0, wb_we}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1; a = 32'd5 + i; b = 32'd11 * i; op = 2'(i); dst = 5'(i);
         step();
         chk("stall_we", {31'd0, wb_we}, 32'd1);
         chk("stall_wn", {27'd0, wb_wn}, 32'd9);
         chk("stall_d", wb_d, 32'd3000);
      end
      wb_gnt = 1'b1;
      step();
      chk("stall_commit_busy", {31'd0, busy}, 32'd0);
      chk("stall_commit_we", {31'd0, wb_we}, 32'd0);
      start = 1'b0;
      step();
      chk("stall_no_reissue", {31'd0, busy}, 32'd0);

      // Destination r0: runs full length, never requests writeback.
      op = 2'b00; a = 32'd3; b = 32'd3; dst = 5'd0; start = 1'b1;
      step();
      start = 1'b0;
      seen = 1'b0;
      repeat (32) begin
         step();
         if (wb_we) seen = 1'b1;
      end
      chk("r0_no_we", {31'd0, seen}, 32'd0);
      chk("r0_idle", {31'd0, busy}, 32'd0);

      // Flush at iteration 10, then immediate reissue.
      op = 2'b10; a = 32'd100; b = 32'd7; dst = 5'd4; start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_we", {31'd0, wb_we}, 32'd0);
      run_op("after_flush", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2);

      // Flush in WB beats a simultaneous grant.
      wb_gnt = 1'b0;
      op = 2'b00; a = 32'd2; b = 32'd2; dst = 5'd6; start = 1'b1;
      step();
      start = 1'b0;
      repeat (32) step();
      chk("wbflush_we_pre", {31'd0, wb_we}, 32'd1);
      flush = 1'b1; wb_gnt = 1'b1;
      step();
      flush = 1'b0;
      chk("wbflush_we", {31'd0, wb_we}, 32'd0);
      chk("wbflush_busy", {31'd0, busy}, 32'd0);

      // Flush in IDLE drops a simultaneous start.
      flush = 1'b1; start = 1'b1;
      step();
      flush = 1'b0; start = 1'b0;
      chk("idle_flush_drop", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-run clears outputs between edges.
      op = 2'b01; a = 32'hFFFF_0000; b = 32'h0001_0000; dst = 5'd7; start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      #2 clrn = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_we", {31'd0, wb_we}, 32'd0);
      chk("arst_wn", {27'd0, wb_wn}, 32'd0);
      chk("arst_d", wb_d, 32'd0);
      step();
      clrn = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         step();
         if (wb_we || busy) seen = 1'b1;
      end
      chk("arst_no_wb", {31'd0, seen}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
